regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/rf_pkg.sv | 26 ++
 rtl/rf_scoreboard.sv | 57 +++++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   XLEN_DEFAULT / NREG_DEFAULT : default data width and register count
//   rf_addr_width()             : register-address width for a given register count
//   rf_word_t / rf_addr_t       : data word and address for the default configuration
//   rf_rd_addr_t / rf_rd_data_t : default two-read-port address and data arrays
//   rf_wr_addr_t / rf_wr_data_t : default one-write-port address and data arrays
package rf_pkg;

   localparam int unsigned XLEN_DEFAULT = 64;
   localparam int unsigned NREG_DEFAULT = 32;

   function automatic int unsigned rf_addr_width(input int unsigned nreg);
      return (nreg <= 2) ? 1 : $clog2(nreg);
   endfunction

   localparam int unsigned AW_DEFAULT = rf_addr_width(NREG_DEFAULT);

   typedef logic [XLEN_DEFAULT-1:0] rf_word_t;
   typedef logic [AW_DEFAULT-1:0]   rf_addr_t;

   typedef logic [1:0][AW_DEFAULT-1:0]   rf_rd_addr_t;
   typedef logic [1:0][XLEN_DEFAULT-1:0] rf_rd_data_t;
   typedef logic [0:0][AW_DEFAULT-1:0]   rf_wr_addr_t;
   typedef logic [0:0][XLEN_DEFAULT-1:0] rf_wr_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for operand-readiness tracking.
//   clock, reset : clock and asynchronous active-high reset
//   wr_act       : per write port, a qualified write (enabled, non-zero address, not in reset)
//   wr_addr      : write address per port; an active write clears its busy bit
//   iss_act      : qualified issue; sets busy[iss_rd]
//   iss_rd       : pending destination
//   rd_addr      : read address per port
//   rd_ready     : per read port, operand not pending (or being written this cycle)
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned NREG = NREG_DEFAULT,
   parameter int unsigned NRD  = 2,
   parameter int unsigned NWR  = 1,
   localparam int unsigned AW  = rf_addr_width(NREG)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NWR-1:0]         wr_act,
   input  logic [NWR-1:0][AW-1:0] wr_addr,
   input  logic                   iss_act,
   input  logic [AW-1:0]          iss_rd,
   input  logic [NRD-1:0][AW-1:0] rd_addr,
   output logic [NRD-1:0]         rd_ready
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Clears first, then the issue set, so a same-cycle issue and write leave the bit set.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned p = 0; p < NWR; p++) begin
         if (wr_act[p]) busy_d[wr_addr[p]] = 1'b0;
      end
      if (iss_act) busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   // A write landing this cycle makes the operand available through the bypass.
   always_comb begin
      rd_ready = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         rd_ready[i] = ~busy_q[rd_addr[i]];
         for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_act[p] && (wr_addr[p] == rd_addr[i])) rd_ready[i] = 1'b1;
         end
         if (rd_addr[i] == '0) rd_ready[i] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, write bypass and a busy scoreboard.
//   clock, reset      : clock and asynchronous active-high reset
//   rd_addr/rd_data   : NRD read ports (combinational or registered per SYNC_READ)
//   rd_ready          : per read port, operand not pending in the scoreboard
//   wr_en/addr/data   : NWR write ports; highest-indexed port wins on a collision
//   iss_en/iss_rd     : mark a destination register pending
//   dbg_addr/dbg_data : raw stored contents, no bypass
module regfile_mp
   import rf_pkg::*;
#(
   parameter int unsigned XLEN      = XLEN_DEFAULT,
   parameter int unsigned NREG      = NREG_DEFAULT,
   parameter int unsigned NRD       = 2,
   parameter int unsigned NWR       = 1,
   parameter bit          SYNC_READ = 1'b0,
   localparam int unsigned AW       = rf_addr_width(NREG)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NRD-1:0][AW-1:0]   rd_addr,
   output logic [NRD-1:0][XLEN-1:0] rd_data,
   output logic [NRD-1:0]           rd_ready,
   input  logic [NWR-1:0]           wr_en,
   input  logic [NWR-1:0][AW-1:0]   wr_addr,
   input  logic [NWR-1:0][XLEN-1:0] wr_data,
   input  logic                     iss_en,
   input  logic [AW-1:0]            iss_rd,
   input  logic [AW-1:0]            dbg_addr,
   output logic [XLEN-1:0]          dbg_data
);

   logic [NREG-1:0][XLEN-1:0] regs_q;
   logic [NWR-1:0]            wr_act;
   logic                      iss_act;
   logic [NRD-1:0][XLEN-1:0]  byp_data;

   // Qualified requests: nothing during reset and nothing aimed at x0.
   always_comb begin
      wr_act = '0;
      for (int unsigned p = 0; p < NWR; p++) begin
         wr_act[p] = wr_en[p] & ~reset & (wr_addr[p] != '0);
      end
      iss_act = iss_en & ~reset & (iss_rd != '0);
   end

   // Later nonblocking assignments override earlier ones, giving the highest port priority.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regs_q <= '0;
      end else begin
         for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_act[p]) regs_q[wr_addr[p]] <= wr_data[p];
         end
      end
   end

   // Post-write view of each read address; shared by both read modes.
   always_comb begin
      byp_data = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         byp_data[i] = regs_q[rd_addr[i]];
         for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_act[p] && (wr_addr[p] == rd_addr[i])) byp_data[i] = wr_data[p];
         end
         if (rd_addr[i] == '0) byp_data[i] = '0;
      end
   end

   if (SYNC_READ) begin : g_sync_read
      logic [NRD-1:0][XLEN-1:0] rd_data_q;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) rd_data_q <= '0;
         else       rd_data_q <= byp_data;
      end

      assign rd_data = rd_data_q;
   end else begin : g_comb_read
      assign rd_data = byp_data;
   end

   // x0 is never written, so it stays at its reset value of zero.
   assign dbg_data = regs_q[dbg_addr];

   rf_scoreboard #(
      .NREG (NREG),
      .NRD  (NRD),
      .NWR  (NWR)
   ) u_scoreboard (
      .clock    (clock),
      .reset    (reset),
      .wr_act   (wr_act),
      .wr_addr  (wr_addr),
      .iss_act  (iss_act),
      .iss_rd   (iss_rd),
      .rd_addr  (rd_addr),
      .rd_ready (rd_ready)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: dut0 has two write ports and combinational reads, dut1 has one
// write port (port 0 of the shared stimulus) and registered reads.
module tb_regfile_mp;
   import rf_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   rf_rd_addr_t rd_addr = '0;
   logic [1:0]  wr_en = '0;
   logic [1:0][AW_DEFAULT-1:0]   wr_addr = '0;
   logic [1:0][XLEN_DEFAULT-1:0] wr_data = '0;
   logic        iss_en = 1'b0;
   rf_addr_t    iss_rd = '0;
   rf_addr_t    dbg_addr = '0;

   rf_rd_data_t rd_data0, rd_data1;
   logic [1:0]  rdy0, rdy1;
   rf_word_t    dbg_data0, dbg_data1;

   always #5 clock = ~clock;

   regfile_mp #(
      .XLEN(XLEN_DEFAULT), .NREG(NREG_DEFAULT), .NRD(2), .NWR(2), .SYNC_READ(1'b0)
   ) dut0 (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_ready(rdy0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data0)
   );

   regfile_mp #(
      .XLEN(XLEN_DEFAULT), .NREG(NREG_DEFAULT), .NRD(2), .NWR(1), .SYNC_READ(1'b1)
   ) dut1 (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_ready(rdy1),
      .wr_en(wr_en[0:0]), .wr_addr(wr_addr[0:0]), .wr_data(wr_data[0:0]), .iss_en(iss_en),
      .iss_rd(iss_rd), .dbg_addr(dbg_addr), .dbg_data(dbg_data1)
   );

   typedef struct {
      rf_word_t   d0, d1;
      logic [1:0] rdy0, rdy1;
      rf_word_t   dbg0, dbg1;
   } comb_exp_t;

   typedef struct {
      rf_word_t d0, d1;
   } sync_exp_t;

   comb_exp_t q_comb[$];
   sync_exp_t q_sync[$];

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: index 0 mirrors dut0, index 1 mirrors dut1.
   rf_word_t mregs [2][32];
   logic     mbusy [2][32];

   logic [1:0] s_we;
   rf_addr_t   s_wa0, s_wa1;
   rf_word_t   s_wd0, s_wd1;
   logic       s_ie;
   rf_addr_t   s_ir;

   task automatic check_eq(input string tag, input rf_word_t got, input rf_word_t exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic rf_word_t m_read(input int m, input rf_addr_t a);
      rf_word_t v = mregs[m][a];
      if (s_we[0] && s_wa0 == a) v = s_wd0;
      if (m == 0 && s_we[1] && s_wa1 == a) v = s_wd1;
      if (a == 0) v = '0;
      return v;
   endfunction

   function automatic logic m_ready(input int m, input rf_addr_t a);
      if (a == 0 || !mbusy[m][a]) return 1'b1;
      if (s_we[0] && s_wa0 == a) return 1'b1;
      if (m == 0 && s_we[1] && s_wa1 == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_update();
      for (int m = 0; m < 2; m++) begin
         if (s_we[0] && s_wa0 != 0) begin
            mregs[m][s_wa0] = s_wd0;
            mbusy[m][s_wa0] = 1'b0;
         end
         if (m == 0 && s_we[1] && s_wa1 != 0) begin
            mregs[m][s_wa1] = s_wd1;
            mbusy[m][s_wa1] = 1'b0;
         end
         if (s_ie && s_ir != 0) mbusy[m][s_ir] = 1'b1;
      end
   endtask

   task automatic m_clear();
      sync_exp_t z;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 32; i++) begin
            mregs[m][i] = '0;
            mbusy[m][i] = 1'b0;
         end
      end
      q_comb.delete();
      q_sync.delete();
      z.d0 = '0;
      z.d1 = '0;
      q_sync.push_back(z);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_d0a"}, rd_data0[0], '0);
      check_eq({tag, "_d0b"}, rd_data0[1], '0);
      check_eq({tag, "_d1a"}, rd_data1[0], '0);
      check_eq({tag, "_d1b"}, rd_data1[1], '0);
      check_eq({tag, "_rdy0"}, rf_word_t'(rdy0), 64'd3);
      check_eq({tag, "_rdy1"}, rf_word_t'(rdy1), 64'd3);
      check_eq({tag, "_dbg0"}, dbg_data0, '0);
      check_eq({tag, "_dbg1"}, dbg_data1, '0);
   endtask

   // One clock cycle: drive, predict, sample at the falling edge, advance the model.
   task automatic cycle(input string tag, input logic [1:0] we, input rf_addr_t wa0,
                        input rf_word_t wd0, input rf_addr_t wa1, input rf_word_t wd1,
                        input logic ie, input rf_addr_t ir, input rf_addr_t ra0,
                        input rf_addr_t ra1, input rf_addr_t da);
      comb_exp_t ce;
      sync_exp_t se;
      s_we = we; s_wa0 = wa0; s_wd0 = wd0; s_wa1 = wa1; s_wd1 = wd1; s_ie = ie; s_ir = ir;
      wr_en = we;
      wr_addr[0] = wa0; wr_addr[1] = wa1;
      wr_data[0] = wd0; wr_data[1] = wd1;
      iss_en = ie; iss_rd = ir;
      rd_addr[0] = ra0; rd_addr[1] = ra1;
      dbg_addr = da;

      ce.d0   = m_read(0, ra0);
      ce.d1   = m_read(0, ra1);
      ce.rdy0 = {m_ready(0, ra1), m_ready(0, ra0)};
      ce.rdy1 = {m_ready(1, ra1), m_ready(1, ra0)};
      ce.dbg0 = mregs[0][da];
      ce.dbg1 = mregs[1][da];
      q_comb.push_back(ce);
      se.d0 = m_read(1, ra0);
      se.d1 = m_read(1, ra1);
      q_sync.push_back(se);

      @(negedge clock);
      ce = q_comb.pop_front();
      se = q_sync.pop_front();
      check_eq({tag, "_c_d0"}, rd_data0[0], ce.d0);
      check_eq({tag, "_c_d1"}, rd_data0[1], ce.d1);
      check_eq({tag, "_c_rdy"}, rf_word_t'(rdy0), rf_word_t'(ce.rdy0));
      check_eq({tag, "_c_dbg"}, dbg_data0, ce.dbg0);
      check_eq({tag, "_s_d0"}, rd_data1[0], se.d0);
      check_eq({tag, "_s_d1"}, rd_data1[1], se.d1);
      check_eq({tag, "_s_rdy"}, rf_word_t'(rdy1), rf_word_t'(ce.rdy1));
      check_eq({tag, "_s_dbg"}, dbg_data1, ce.dbg1);

      @(posedge clock);
      m_update();
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_rd = '0;
      rd_addr = '0; dbg_addr = '0;
   endtask

   initial begin
      // Requests presented during reset must have no visible effect.
      wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd6;
      wr_data[0] = 64'h1234; wr_data[1] = 64'h5678;
      iss_en = 1'b1; iss_rd = 5'd5;
      rd_addr[0] = 5'd5; rd_addr[1] = 5'd6; dbg_addr = 5'd5;
      @(posedge clock);
      @(negedge clock);
      check_reset_outputs("rst");
      idle_inputs();
      reset = 1'b0;
      m_clear();
      @(posedge clock);
      #1;

      // x5 not written during reset, not busy
      cycle("rst_x5", 2'b00, 0, 0, 0, 0, 0, 0, 5, 6, 5);
      // write x5, same-cycle bypass, then plain read and debug read
      cycle("wr_x5", 2'b01, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 5, 5, 5);
      cycle("rd_x5", 2'b00, 0, 0, 0, 0, 0, 0, 5, 0, 5);
      // writes to x0 are dropped
      cycle("wr_x0", 2'b01, 0, 64'hFFFF, 0, 0, 0, 0, 0, 0, 0);
      cycle("rd_x0", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // two ports hit x7; port 1 wins on dut0
      cycle("wr_x7", 2'b11, 7, 64'h11, 7, 64'h22, 0, 0, 7, 7, 7);
      cycle("rd_x7", 2'b00, 0, 0, 0, 0, 0, 0, 7, 5, 7);
      // issue x9, observe busy, clear by write with bypass
      cycle("iss_x9", 2'b00, 0, 0, 0, 0, 1, 9, 9, 0, 9);
      cycle("busy_x9", 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 9);
      cycle("wr_x9", 2'b01, 9, 64'h33, 0, 0, 0, 0, 9, 9, 9);
      cycle("clr_x9", 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 9);
      // issue and write x4 together: data lands, busy stays set
      cycle("iss_wr_x4", 2'b01, 4, 64'h44, 0, 0, 1, 4, 4, 0, 4);
      cycle("busy_x4", 2'b00, 0, 0, 0, 0, 0, 0, 4, 4, 4);
      // issue to x0 is ignored
      cycle("iss_x0", 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      // registered read of a same-cycle write to x3
      cycle("wr_x3", 2'b01, 3, 64'h55, 0, 0, 0, 0, 3, 3, 3);
      cycle("rd_x3", 2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 3);

      // Reset asserted mid-cycle alongside a write and an issue to x3.
      wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 64'h77;
      iss_en = 1'b1; iss_rd = 5'd3;
      rd_addr[0] = 5'd3; rd_addr[1] = 5'd3; dbg_addr = 5'd3;
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      @(posedge clock);
      @(negedge clock);
      check_reset_outputs("mid_rst_edge");
      idle_inputs();
      reset = 1'b0;
      m_clear();
      @(posedge clock);
      #1;
      cycle("post_rst_x3", 2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 3);

      // Random traffic over a small address window to force collisions.
      for (int n = 0; n < 300; n++) begin
         cycle("rnd", 2'($urandom_range(0, 3)),
               rf_addr_t'($urandom_range(0, 7)), {$urandom(), $urandom()},
               rf_addr_t'($urandom_range(0, 7)), {$urandom(), $urandom()},
               ($urandom_range(0, 3) == 0), rf_addr_t'($urandom_range(0, 7)),
               rf_addr_t'($urandom_range(0, 7)), rf_addr_t'($urandom_range(0, 7)),
               rf_addr_t'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
